// File: rtl/rf_pkg.sv
// Shared constants, clear-FSM state type and read-port slicing helper for the
// multiport register file.
package rf_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  // Bit offset of read port k inside the packed raddr bus.
  function automatic int rf_slice(input int k, input int aw = RF_AW);
    return k * aw;
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear engine: walks every entry once, one per cycle, after reset or on a
// clr_req pulse; requests arriving mid-clear are ignored.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output clr_state_t    clr_state
);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_RUN;
          ptr_d   = '0;
        end
      end
      CLR_RUN: begin
        ptr_d = ptr_q + 1'b1;
        // The last entry is written on this edge, so leave CLEAR on it.
        if (ptr_q == AW'(DEPTH - 1)) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
    busy_d = (state_d == CLR_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLR_RUN;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_busy  = busy_q;
  assign clr_we    = busy_q;
  assign clr_addr  = ptr_q;
  assign clr_state = state_q;

endmodule

// File: rtl/rf_multiport.sv
// Register file with NR_READ combinational read ports, two write ports (port 1
// wins a clash) and a clear engine. Define RF_BYPASS_EN for write-to-read bypass.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = RF_AW,
  parameter int NR_READ  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [AW-1:0]         waddr0,
  input  logic [DW-1:0]         wdata0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr1,
  input  logic [DW-1:0]         wdata1,
  input  logic [NR_READ*AW-1:0] raddr,
  output logic [NR_READ*DW-1:0] rdata,
  input  logic                  clr_req,
  output logic                  clr_busy
);

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  clr_state_t    clr_state;
  logic          wr_open;

  rf_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_state (clr_state)
  );

  assign wr_open = (clr_state == CLR_IDLE);

  // Storage has no reset; the clear engine zeroes it after reset instead.
  logic [DW-1:0]    rf_q      [DEPTH];
  logic [DW-1:0]    rf_wdata_d[DEPTH];
  logic [DEPTH-1:0] rf_we_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rf_we_d[i]    = 1'b0;
      rf_wdata_d[i] = '0;
      if (clr_we) begin
        if (clr_addr == AW'(i)) rf_we_d[i] = 1'b1;
      end else if (wr_open && !(ZERO_REG != 0 && i == 0)) begin
        if (we1 && waddr1 == AW'(i)) begin
          rf_we_d[i]    = 1'b1;
          rf_wdata_d[i] = wdata1;
        end else if (we0 && waddr0 == AW'(i)) begin
          rf_we_d[i]    = 1'b1;
          rf_wdata_d[i] = wdata0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rf_we_d[i]) rf_q[i] <= rf_wdata_d[i];
    end
  end

  for (genvar k = 0; k < NR_READ; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    assign ra = raddr[rf_slice(k, AW) +: AW];

    always_comb begin
      rd = rf_q[ra];
`ifdef RF_BYPASS_EN
      if (wr_open) begin
        if (we1 && waddr1 == ra) rd = wdata1;
        else if (we0 && waddr0 == ra) rd = wdata0;
      end
`endif
      if (ZERO_REG != 0 && ra == '0) rd = '0;
    end

    assign rdata[k*DW +: DW] = rd;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Randomised and directed bench for rf_multiport (NR_READ=4, ZERO_REG=1),
// compared against an array-based reference model.
module tb_rf_multiport;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             we0, we1, clr_req;
  logic [AW-1:0]    waddr0, waddr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic             clr_busy;

  rf_multiport #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NR_READ  (NR),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1),
    .raddr    (raddr),
    .rdata    (rdata),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] mem [DEPTH];
  int            clr_left;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (clr_left == 0) begin
      if (we1 && waddr1 == a) return wdata1;
      if (we0 && waddr0 == a) return wdata0;
    end
`endif
    return mem[a];
  endfunction

  task automatic model_start_clear();
    clr_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  task automatic model_edge();
    if (clr_left == 0) begin
      if (we0 && waddr0 != 0) mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) mem[waddr1] = wdata1;
      if (clr_req) model_start_clear();
    end else begin
      clr_left--;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic set_raddr(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  // Inputs are set at the falling edge; outputs sampled 1ns later.
  task automatic step();
    #1;
    check("busy", DW'(clr_busy), DW'(clr_left != 0));
    if (clr_left == 0) begin
      for (int k = 0; k < NR; k++) exp_q.push_back(exp_read(raddr[k*AW +: AW]));
      for (int k = 0; k < NR; k++) check($sformatf("rd%0d@%0d", k, raddr[k*AW +: AW]),
                                         rdata[k*DW +: DW], exp_q.pop_front());
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_start_clear();
    #1;
    check("busy_in_reset", DW'(clr_busy), DW'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic write2(input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we0 = 1'b1; waddr0 = a0; wdata0 = d0;
    we1 = 1'b1; waddr1 = a1; wdata1 = d1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    raddr = '0;
    @(negedge clk);
    do_reset();

    // Clear after reset: busy for exactly DEPTH cycles, then all zero.
    repeat (DEPTH) step();
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int k = 0; k < NR; k++) set_raddr(k, AW'(a + k));
      step();
    end

    // Port clash on address 5.
    for (int k = 0; k < NR; k++) set_raddr(k, 5'd5);
    write2(5'd5, 32'hAAAA0000, 5'd5, 32'h5555FFFF);
    step();

    // Zero register ignores writes.
    for (int k = 0; k < NR; k++) set_raddr(k, 5'd0);
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEADBEEF;
    step();
    step();

    // Bypass / read-old-value on address 7.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hCAFE0007;
    step();
    set_raddr(0, 5'd7);
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h12345678;
    step();
    step();

    // Clear interactions: dropped write, ignored re-request, reset restart.
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h00000033;
    step();
    clr_req = 1'b1;
    step();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h00000099;
    step();
    repeat (2) step();
    clr_req = 1'b1;
    step();
    repeat (5) step();
    do_reset();
    repeat (DEPTH) step();
    set_raddr(0, 5'd3); set_raddr(1, 5'd5); set_raddr(2, 5'd7); set_raddr(3, 5'd31);
    step();

    // Four ports, four distinct addresses.
    write2(5'd1, 32'h11, 5'd2, 32'h22);
    write2(5'd3, 32'h33, 5'd4, 32'h44);
    for (int k = 0; k < NR; k++) set_raddr(k, AW'(k + 1));
    step();

    // Random traffic with occasional clear requests.
    for (int n = 0; n < 600; n++) begin
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      waddr0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      waddr1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wdata0 = $urandom;
      wdata1 = $urandom;
      clr_req = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < NR; k++) begin
        case ($urandom_range(0, 3))
          0:       set_raddr(k, waddr0);
          1:       set_raddr(k, waddr1);
          default: set_raddr(k, AW'($urandom));
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
